// File: rtl/button_capture.sv
// button_capture: synchronize, debounce and pack active-low push buttons into a status word
module button_capture #(
  parameter int N_BUTTONS = 4,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_BUTTONS-1:0] button_n,
  output logic [31:0]          register_button,
  output logic [N_BUTTONS-1:0] press_pulse
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  logic [N_BUTTONS-1:0] sync [SYNC_STAGES];
  logic [N_BUTTONS-1:0] s, stable, level, last, press;
  logic [15:0] count;
  logic [CW-1:0] cnt [N_BUTTONS];
  assign s = ~sync[SYNC_STAGES-1];
  assign press = stable & ~level;
  assign register_button = {count, 8'(last), 8'(level)};
  // shift raw keys through the synchronizer chain, idling at released
  always_ff @(posedge clk or posedge rst)
    if (rst) for (int k = 0; k < SYNC_STAGES; k++) sync[k] <= '1;
    else begin
      sync[0] <= button_n;
      for (int k = 1; k < SYNC_STAGES; k++) sync[k] <= sync[k-1];
    end
  // per key: count consecutive disagreeing cycles, flip stable once the run is long enough
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      stable <= '0;
      for (int k = 0; k < N_BUTTONS; k++) cnt[k] <= '0;
    end else
      for (int k = 0; k < N_BUTTONS; k++)
        if (s[k] == stable[k]) cnt[k] <= '0;
        else if (cnt[k] == CW'(DEBOUNCE_CYCLES - 1)) begin
          stable[k] <= s[k];
          cnt[k] <= '0;
        end else cnt[k] <= cnt[k] + CW'(1);
  // register the packed word one cycle after a debounced change; only presses touch LAST/COUNT
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      level <= '0;
      last <= '0;
      count <= '0;
      press_pulse <= '0;
    end else begin
      level <= stable;
      press_pulse <= press;
      if (|press) begin
        last <= press;
        count <= count + 16'd1;
      end
    end
endmodule

// File: tb/tb_button_capture.sv
// tb_button_capture: randomized and directed checks against a sample-window reference model
module tb_button_capture;
  localparam int D = 8;
  logic clk = 0, rst = 1;
  logic [3:0] button_n = 4'hF;
  logic [31:0] register_button;
  logic [3:0] press_pulse;
  int checks = 0, failures = 0;
  logic [3:0] hq[$];
  logic [3:0] m_stable, m_level, m_last, m_pulse;
  logic [15:0] m_count;

  button_capture #(.N_BUTTONS(4), .DEBOUNCE_CYCLES(D), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .button_n(button_n),
    .register_button(register_button), .press_pulse(press_pulse));

  always #5 clk = ~clk;

  // history of pressed samples; keys held before reset count as released
  function automatic void model_reset();
    hq.delete();
    for (int i = 0; i < D + 2; i++) hq.push_back(4'h0);
    m_stable = 0; m_level = 0; m_last = 0; m_pulse = 0; m_count = 0;
  endfunction

  // a key's debounced level flips once D consecutive samples, taken two edges back, all disagree
  function automatic void model_edge(input logic [3:0] r);
    logic [3:0] p, all_p, all_r;
    p = m_stable & ~m_level;
    m_pulse = p;
    m_level = m_stable;
    if (p != 0) begin
      m_last = p;
      m_count = m_count + 16'd1;
    end
    hq.push_back(r);
    void'(hq.pop_front());
    all_p = '1; all_r = '1;
    for (int k = 0; k < D; k++) begin
      all_p &= hq[k];
      all_r &= ~hq[k];
    end
    m_stable = (m_stable & ~all_r) | (~m_stable & all_p);
  endfunction

  function automatic logic [31:0] m_word();
    return {m_count, 4'h0, m_last, 4'h0, m_level};
  endfunction

  task automatic tick();
    @(posedge clk);
    if (rst) model_reset();
    else model_edge(~button_n);
    #1;
  endtask

  task automatic test_reset();
    rst = 1; button_n = 4'hF;
    repeat (3) tick();
    checks++;
    if (register_button !== 32'h0 || press_pulse !== 4'h0) begin
      failures++;
      $display("FAIL reset: word=%h pulse=%b want word=00000000 pulse=0000", register_button, press_pulse);
    end
    rst = 0;
  endtask

  task automatic test_single_press();
    button_n = 4'hE;
    for (int c = 1; c <= 20; c++) begin
      tick();
      checks++;
      if (register_button !== m_word() || press_pulse !== m_pulse) begin
        failures++;
        $display("FAIL single_model c=%0d: word=%h pulse=%b want %h %b", c, register_button, press_pulse, m_word(), m_pulse);
      end
      if (c == 10 || c == 11 || c == 12) begin
        checks++;
        if (press_pulse !== (c == 11 ? 4'b0001 : 4'b0000) || (c >= 11 && register_button !== 32'h0001_0101)) begin
          failures++;
          $display("FAIL single_press c=%0d: word=%h pulse=%b want 00010101 pulse only at c=11", c, register_button, press_pulse);
        end
      end
    end
    button_n = 4'hF;
    repeat (12) tick();
    checks++;
    if (register_button !== 32'h0001_0100 || press_pulse !== 4'h0) begin
      failures++;
      $display("FAIL single_release: word=%h pulse=%b want 00010100 0000", register_button, press_pulse);
    end
  endtask

  task automatic test_glitch();
    button_n = 4'hB;
    for (int c = 1; c <= 20; c++) begin
      if (c == 6) button_n = 4'hF;
      tick();
      checks++;
      if (register_button !== 32'h0001_0100 || press_pulse !== 4'h0) begin
        failures++;
        $display("FAIL glitch c=%0d: word=%h pulse=%b want 00010100 0000", c, register_button, press_pulse);
      end
    end
  endtask

  task automatic test_simultaneous();
    button_n = 4'h5;
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (c == 11) begin
        checks++;
        if (register_button !== 32'h0002_0A0A || press_pulse !== 4'b1010) begin
          failures++;
          $display("FAIL simultaneous: word=%h pulse=%b want 00020a0a 1010", register_button, press_pulse);
        end
      end
    end
    checks++;
    if (press_pulse !== 4'h0 || register_button !== m_word()) begin
      failures++;
      $display("FAIL simultaneous_after: word=%h pulse=%b want %h 0000", register_button, press_pulse, m_word());
    end
    button_n = 4'hF;
    repeat (12) tick();
  endtask

  task automatic test_wrap();
    force dut.count = 16'hFFFF;
    tick();
    release dut.count;
    m_count = 16'hFFFF;
    button_n = 4'hE;
    for (int c = 1; c <= 12; c++) begin
      tick();
      checks++;
      if (register_button !== m_word() || press_pulse !== m_pulse) begin
        failures++;
        $display("FAIL wrap_model c=%0d: word=%h pulse=%b want %h %b", c, register_button, press_pulse, m_word(), m_pulse);
      end
    end
    checks++;
    if (register_button[31:16] !== 16'h0000 || register_button[15:8] !== 8'h01) begin
      failures++;
      $display("FAIL wrap: count=%h last=%h want 0000 01", register_button[31:16], register_button[15:8]);
    end
    button_n = 4'hF;
    repeat (12) tick();
  endtask

  task automatic test_reset_mid();
    button_n = 4'hE;
    repeat (5) tick();
    #2 rst = 1;
    #1 model_reset();
    checks++;
    if (register_button !== 32'h0 || press_pulse !== 4'h0) begin
      failures++;
      $display("FAIL reset_mid: word=%h pulse=%b want 00000000 0000", register_button, press_pulse);
    end
    repeat (2) tick();
    rst = 0;
    for (int c = 1; c <= 14; c++) begin
      tick();
      checks++;
      if (register_button !== m_word() || press_pulse !== m_pulse) begin
        failures++;
        $display("FAIL reset_hold_model c=%0d: word=%h pulse=%b want %h %b", c, register_button, press_pulse, m_word(), m_pulse);
      end
      if (c == 10 || c == 11) begin
        checks++;
        if (register_button !== (c == 11 ? 32'h0001_0101 : 32'h0)) begin
          failures++;
          $display("FAIL reset_hold c=%0d: word=%h want %h", c, register_button, c == 11 ? 32'h0001_0101 : 32'h0);
        end
      end
    end
    button_n = 4'hF;
    repeat (12) tick();
  endtask

  task automatic test_random();
    int hold;
    for (int n = 0; n < 80; n++) begin
      button_n = 4'($urandom);
      hold = $urandom_range(1, 14);
      for (int c = 0; c < hold; c++) begin
        tick();
        checks++;
        if (register_button !== m_word() || press_pulse !== m_pulse) begin
          failures++;
          $display("FAIL random n=%0d c=%0d: word=%h pulse=%b want %h %b", n, c, register_button, press_pulse, m_word(), m_pulse);
        end
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single_press();
    test_glitch();
    test_simultaneous();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
